// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI peripheral endpoint, MSB-first, all CPOL/CPHA modes, buffered TX byte
module spi_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_empty,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS_N,
    output logic       MISO,
    output logic       miso_oe
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t      state;
    logic [2:0]  sclk_s;
    logic [2:0]  ss_s;
    logic [1:0]  mosi_s;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_buf;
    logic        sclk_chg;
    logic        lead;
    logic        trail;
    logic        sample;
    logic        drive;
    logic        ss_fall;
    logic [7:0]  next_tx;
    logic [7:0]  rx_next;
    assign sclk_chg = sclk_s[1] ^ sclk_s[2];
    assign lead     = sclk_chg & (sclk_s[1] ^ cpol);
    assign trail    = sclk_chg & ~(sclk_s[1] ^ cpol);
    assign sample   = cpha ? trail : lead;
    assign drive    = cpha ? lead : trail;
    assign ss_fall  = ss_s[2] & ~ss_s[1];
    assign next_tx  = tx_write ? tx_data : (tx_empty ? 8'hFF : tx_buf);
    assign rx_next  = {rx_shift[6:0], mosi_s[1]};
    assign MISO     = busy & tx_shift[7];
    assign miso_oe  = busy;
    // two-flop synchronizers for the bus pins, third SCLK/SS_N flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s <= '0;
            ss_s   <= '1;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], SCLK};
            ss_s   <= {ss_s[1:0], SS_N};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end
    // transfer FSM: select handling, shift registers, TX buffer and received byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_empty <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (tx_write) begin
                tx_buf   <= tx_data;
                tx_empty <= 1'b0;
            end
            if (state == IDLE) begin
                if (ss_fall) begin
                    state    <= ACTIVE;
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    tx_shift <= next_tx;
                    tx_empty <= 1'b1;
                end
            end else if (ss_s[1]) begin
                state    <= IDLE;
                busy     <= 1'b0;
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else begin
                if (sample) begin
                    rx_shift <= rx_next;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data  <= rx_next;
                        rx_valid <= 1'b1;
                        if (cpha) begin
                            tx_shift <= next_tx;
                            tx_empty <= 1'b1;
                        end
                    end
                end
                if (drive) begin
                    if (!cpha && bit_cnt == 3'd0) begin
                        tx_shift <= next_tx;
                        tx_empty <= 1'b1;
                    end else if (!cpha || bit_cnt != 3'd0) begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed table-driven bench acting as SPI master against spi_slave
module tb_spi_slave;
    localparam int H = 10;
    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       wr;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    logic       clk;
    logic       reset;
    logic       cpol;
    logic       cpha;
    logic [7:0] tx_data;
    logic       tx_write;
    logic       tx_empty;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCLK;
    logic       MOSI;
    logic       SS_N;
    logic       MISO;
    logic       miso_oe;
    int         checks;
    int         failures;
    int         vcnt;
    int         v0;
    logic [7:0] rx_log [0:15];
    logic [7:0] m;
    logic [7:0] m2;
    vec_t       vecs [0:4];

    spi_slave dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_write(tx_write), .tx_empty(tx_empty),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N), .MISO(MISO), .miso_oe(miso_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // log every cycle rx_valid is high, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (vcnt < 16) rx_log[vcnt] = rx_data;
            vcnt = vcnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        tx_data  = d;
        tx_write = 1'b1;
        tick(1);
        tx_write = 1'b0;
    endtask

    task automatic ss_low();
        SS_N = 1'b0;
        tick(H);
    endtask

    task automatic ss_high();
        tick(H);
        SS_N = 1'b1;
        tick(H);
    endtask

    // master side of n bits, MSB first; returns bits seen on MISO
    task automatic xfer(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - n; i--) begin
            if (!cpha) begin
                MOSI = mo[i];
                tick(H);
                SCLK = ~cpol;
                mi = {mi[6:0], MISO};
                tick(H);
                SCLK = cpol;
            end else begin
                tick(H);
                SCLK = ~cpol;
                MOSI = mo[i];
                tick(H);
                SCLK = cpol;
                mi = {mi[6:0], MISO};
            end
        end
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        SCLK = p;
        tick(4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vcnt     = 0;
        reset    = 1'b0;
        SS_N     = 1'b1;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_write = 1'b0;
        tx_data  = '0;
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h96, 8'h5A, 8'h5A, 8'h96};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h96, 8'h5A, 8'h5A, 8'h96};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h96, 8'h5A, 8'h5A, 8'h96};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hC5, 8'hC5, 8'hFF};
        tick(3);
        check("rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_miso", {31'd0, MISO}, 32'h0);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'h0);
        check("rst_tx_empty", {31'd0, tx_empty}, 32'h1);
        reset = 1'b1;
        tick(3);

        for (int k = 0; k < 5; k++) begin
            set_mode(vecs[k].cpol, vecs[k].cpha);
            if (vecs[k].wr) write_tx(vecs[k].tx);
            check("pre_tx_empty", {31'd0, tx_empty}, {31'd0, ~vecs[k].wr});
            v0 = vcnt;
            ss_low();
            check("sel_tx_empty", {31'd0, tx_empty}, 32'h1);
            check("sel_busy", {31'd0, busy}, 32'h1);
            check("sel_miso_oe", {31'd0, miso_oe}, 32'h1);
            xfer(vecs[k].mosi, 8, m);
            ss_high();
            check("vec_miso_byte", {24'd0, m}, {24'd0, vecs[k].exp_miso});
            check("vec_rx_data", {24'd0, rx_data}, {24'd0, vecs[k].exp_rx});
            check("vec_rx_valid_cnt", vcnt - v0, 32'd1);
            check("vec_busy_off", {31'd0, busy}, 32'h0);
            check("vec_miso_off", {31'd0, MISO}, 32'h0);
        end

        // two bytes under one select, buffer refilled after the first load
        set_mode(1'b0, 1'b0);
        write_tx(8'hC3);
        v0 = vcnt;
        ss_low();
        check("two_tx_empty_load", {31'd0, tx_empty}, 32'h1);
        write_tx(8'h0F);
        check("two_tx_refill", {31'd0, tx_empty}, 32'h0);
        xfer(8'h11, 8, m);
        xfer(8'h22, 8, m2);
        ss_high();
        check("two_miso_b0", {24'd0, m}, 32'hC3);
        check("two_miso_b1", {24'd0, m2}, 32'h0F);
        check("two_valid_cnt", vcnt - v0, 32'd2);
        check("two_rx_b0", {24'd0, rx_log[v0]}, 32'h11);
        check("two_rx_b1", {24'd0, rx_log[v0 + 1]}, 32'h22);

        // abort after 5 bits, then a full byte
        v0 = vcnt;
        write_tx(8'h55);
        ss_low();
        xfer(8'hAA, 5, m);
        ss_high();
        check("abort_no_valid", vcnt - v0, 32'd0);
        check("abort_rx_keep", {24'd0, rx_data}, 32'h22);
        check("abort_busy_off", {31'd0, busy}, 32'h0);
        write_tx(8'h3C);
        ss_low();
        xfer(8'h81, 8, m);
        ss_high();
        check("abort_next_rx", {24'd0, rx_data}, 32'h81);
        check("abort_next_cnt", vcnt - v0, 32'd1);
        check("abort_next_miso", {24'd0, m}, 32'h3C);

        // asynchronous reset after 4 bits, then a clean transfer
        v0 = vcnt;
        write_tx(8'h77);
        ss_low();
        write_tx(8'h99);
        xfer(8'hE7, 4, m);
        check("mid_busy", {31'd0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("arst_rx_data", {24'd0, rx_data}, 32'h0);
        check("arst_busy", {31'd0, busy}, 32'h0);
        check("arst_miso", {31'd0, MISO}, 32'h0);
        check("arst_miso_oe", {31'd0, miso_oe}, 32'h0);
        check("arst_tx_empty", {31'd0, tx_empty}, 32'h1);
        check("arst_rx_valid", {31'd0, rx_valid}, 32'h0);
        SS_N = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(5);
        check("arst_no_valid", vcnt - v0, 32'd0);
        write_tx(8'h5A);
        ss_low();
        xfer(8'hE7, 8, m);
        ss_high();
        check("post_rst_rx", {24'd0, rx_data}, 32'hE7);
        check("post_rst_miso", {24'd0, m}, 32'h5A);
        check("post_rst_cnt", vcnt - v0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
